// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   DATA_BITS  : payload bits per frame (8N1)
//   clog2()    : counter width helper usable in constant expressions
//   maj3()     : 2-of-3 majority vote, used by the optional sampler voting
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Brings the asynchronous serial line into the clk domain and provides the
// value the receiver FSM uses for its bit decisions.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (flops reset to idle-high)
//   rx_phy     in   raw serial line, idle high, asynchronous to clk
//   rx_s       out  rx_phy after a 2-FF synchroniser
//   sample_bit out  decision value, meaningful in the FSM's decision cycle
//
// Optional build macro UART_RX_MAJORITY_EN:
//   defined   -> sample_bit is the 2-of-3 vote of rx_s over the current and
//                two previous cycles (decision cycle is one later in the FSM)
//   undefined -> sample_bit is rx_s itself
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_phy,
  output logic rx_s,
  output logic sample_bit
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_phy;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // Two history taps: with the live rx_s they cover cnt HALF-1..HALF+1 when
  // the FSM decides at HALF+1.
  logic tap1_q;
  logic tap2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap1_q <= 1'b1;
      tap2_q <= 1'b1;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
    end
  end

  assign sample_bit = maj3(sync2_q, tap1_q, tap2_q);
`else
  assign sample_bit = sync2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with valid/ready byte output, overrun and framing-error
// pulses. LSB first, mid-bit sampling.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (>= 4), default 125 MHz / 115200
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx_phy     in   serial line, idle high, asynchronous to clk
//   rx_data    out  last received byte
//   rx_valid   out  rx_data holds an unconsumed byte
//   rx_ready   in   consumer takes rx_data when rx_valid && rx_ready
//   rx_busy    out  receiver FSM is not idle
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: new byte replaced an unconsumed one
//
// Optional build macro UART_RX_MAJORITY_EN: bit decisions use a 2-of-3 vote
// around mid-bit and are taken one cycle later (cnt == HALF+1).
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_phy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int IDX_W = clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_AT = HALF + 1;
`else
  localparam int DECIDE_AT = HALF;
`endif

  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(DECIDE_AT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic sample_bit;

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_phy     (rx_phy),
    .rx_s       (rx_s),
    .sample_bit (sample_bit)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // Consumer handshake; a byte completing in the same cycle re-sets valid below.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_DECIDE && sample_bit) begin
          // Line back high by mid start bit: treat as a glitch.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_DECIDE) begin
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_DECIDE) begin
          cnt_d = '0;
          if (sample_bit) begin
            state_d = IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ready;
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
          end
        end
      end

      BREAK: begin
        // Wait for the line to return high so a held-low line cannot restart.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = HALF + 1;
`else
  localparam int DEC = HALF;
`endif
  // start-edge to rx_valid: sync (2) + start and 8 data bits + mid-stop + register
  localparam int LATENCY = 2 + 9 * CPB + DEC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_phy;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_phy    (rx_phy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         ovr;
  } exp_t;

  exp_t exp_q[$];
  bit   pending = 1'b0;   // model: a delivered byte has not been consumed yet
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every presented byte or framing error pops one expectation.
  initial begin : monitor
    logic pv, pr, new_byte;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        // New byte: valid now, and previously empty, accepted, or replaced.
        new_byte = rx_valid && (!pv || pr || overrun);
        if (rx_valid && !pv) rise_cyc = cyc;
        if (new_byte || frame_err) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_output: got ferr=%0b data=%02h ovr=%0b, required no output",
                     frame_err, rx_data, overrun);
          end else begin
            e = exp_q.pop_front();
            if (e.is_ferr != frame_err ||
                (!e.is_ferr && (rx_data != e.data || overrun != e.ovr))) begin
              mismatched++;
              $display("FAIL scoreboard: got ferr=%0b data=%02h ovr=%0b, required ferr=%0b data=%02h ovr=%0b",
                       frame_err, rx_data, overrun, e.is_ferr, e.data, e.ovr);
            end else begin
              $display("rx event ok: ferr=%0b data=%02h ovr=%0b", frame_err, rx_data, overrun);
            end
          end
        end
        pv = rx_valid;
        pr = rx_valid && rx_ready;
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, req, req);
    end else begin
      $display("check ok: %s = %0d", name, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    e.is_ferr = 1'b0;
    e.data    = b;
    e.ovr     = pending;
    exp_q.push_back(e);
    pending = !rx_ready;
  endtask

  task automatic push_ferr();
    exp_t e;
    e.is_ferr = 1'b1;
    e.data    = 8'h00;
    e.ovr     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    if (glitch) begin
      rx_phy = v;  tick(HALF);
      rx_phy = !v; tick(1);
      rx_phy = v;  tick(CPB - HALF - 1);
    end else begin
      rx_phy = v;
      tick(CPB);
    end
  endtask

  // One 8N1 frame; glitch_bit selects a data bit with a 1-cycle mid-bit flip.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int glitch_bit);
    start_cyc = cyc + 1;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], i == glitch_bit);
    drive_bit(stop_ok, 1'b0);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick(1);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : main
    logic [7:0] b;
    bit ok;
    rst = 1'b1;
    rx_phy = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0;
    tick(5);

    // Single byte, consumer not ready: latency and held data.
    push_byte(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_drain(50);
    chk("latency", rise_cyc - start_cyc, LATENCY);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    pending = 1'b0;
    chk("a5_valid_cleared", rx_valid, 0);

    // Back-to-back frames with the consumer always ready.
    rx_ready = 1'b1;
    push_byte(8'h00); send_frame(8'h00, 1'b1, -1);
    push_byte(8'hFF); send_frame(8'hFF, 1'b1, -1);
    push_byte(8'h3C); send_frame(8'h3C, 1'b1, -1);
    wait_drain(50);

    // Framing error: stop bit low, line held low 3 bits in total.
    push_ferr();
    send_frame(8'h55, 1'b0, -1);
    tick(2 * CPB);
    chk("break_busy", rx_busy, 1);
    chk("break_no_valid", rx_valid, 0);
    rx_phy = 1'b1;
    tick(4);
    chk("break_released", rx_busy, 0);
    push_byte(8'h12); send_frame(8'h12, 1'b1, -1);
    wait_drain(50);

    // Overrun: two bytes without consumption.
    rx_ready = 1'b0;
    tick(2);
    push_byte(8'h11); send_frame(8'h11, 1'b1, -1);
    push_byte(8'h22); send_frame(8'h22, 1'b1, -1);
    wait_drain(50);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    pending = 1'b0;
    chk("ovr_valid_cleared", rx_valid, 0);

    // Short start pulse is rejected.
    start_cyc = cyc + 1;
    rx_phy = 1'b0;
    tick(4);
    chk("glitch_busy_entered", rx_busy, 1);
    rx_phy = 1'b1;
    tick(HALF + 1);
    chk("glitch_back_idle", rx_busy, 0);
    tick(2 * CPB);

    // Reset in the middle of data bit 4 of 0xC3.
    rx_ready = 1'b1;
    b = 8'hC3;
    rx_phy = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b0);
    rx_phy = b[4];
    tick(HALF);
    rst = 1'b1;
    #2;
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_busy", rx_busy, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    rx_phy = 1'b1;
    tick(3);
    rst = 1'b0;
    pending = 1'b0;
    tick(2 * CPB);
    push_byte(8'h7E); send_frame(8'h7E, 1'b1, -1);
    wait_drain(50);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle mid-bit glitches are voted out.
    push_byte(8'h96); send_frame(8'h96, 1'b1, 1);
    push_byte(8'h5A); send_frame(8'h5A, 1'b1, 4);
    wait_drain(50);
`endif

    // Randomized traffic with occasional framing errors.
    rx_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      if (ok) push_byte(b);
      else    push_ferr();
      send_frame(b, ok, -1);
      if (!ok) begin
        tick(CPB * $urandom_range(0, 2));
        rx_phy = 1'b1;
        tick($urandom_range(2, 20));
      end else begin
        tick($urandom_range(0, 20));
      end
    end
    wait_drain(100);
    tick(2 * CPB);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: deserialises the asynchronous `rx_phy` line into bytes for the FizzBuzz core.
- Counterpart of the existing transmit path; instantiated inside `uart_top` next to the transmitter.
- Byte output uses a valid/ready handshake with overrun and framing-error reporting.
- 2-FF input synchroniser, mid-bit sampling, LSB first.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per bit (125 MHz / 115200). Legal range >= 4.
- HALF (localparam), CLKS_PER_BIT/2, sample offset within a bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- rx_phy  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_busy  output  1  high whenever the FSM is not IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a new byte replaced an unconsumed byte.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - Synchroniser flops=1, FSM=IDLE, bit counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever presented.
- Synchroniser: rx_s is rx_phy delayed by 2 clk.
- Bit timer: `cnt` counts 0..CLKS_PER_BIT-1 and is cleared on entry to START. Width is clog2(CLKS_PER_BIT).
- States:
  - IDLE
    - rx_s==0 -> START, cnt=0.
  - START
    - At cnt==HALF: sampled 1 -> IDLE (glitch rejected, no flags). Sampled 0 -> continue.
    - At cnt==CLKS_PER_BIT-1 -> DATA, bit index=0.
  - DATA
    - At cnt==HALF: sample into the shift register, LSB first.
    - At cnt==CLKS_PER_BIT-1: index 7 -> STOP, otherwise index+1.
  - STOP
    - At cnt==HALF, the stop bit is decided:
      - 1 -> load rx_data, set rx_valid, -> IDLE.
      - 0 -> frame_err pulse, rx_data/rx_valid unchanged, -> BREAK.
    - STOP exits at mid-stop-bit so the receiver can resync on back-to-back frames.
  - BREAK
    - rx_s==1 -> IDLE. A held-low line never retriggers START.
- rx_data/rx_valid update in the cycle after the stop decision cycle.
- Latency, rx_phy start edge to rx_valid high: 2 + 9*CLKS_PER_BIT + HALF + 1 cycles.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears.
  - rx_data is stable while rx_valid=1, unless an overrun occurs.
- Byte completion while rx_valid=1 and rx_ready=0:
  - rx_data is overwritten, rx_valid stays 1, overrun pulses for 1 cycle.
- Byte completion in the same cycle as rx_valid&&rx_ready:
  - new data loaded, rx_valid stays 1, no overrun.
- rx_busy = (state != IDLE), registered together with the state.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each START/DATA/STOP decision is the 2-of-3 majority of rx_s at cnt HALF-1, HALF and HALF+1.
  - The decision is taken at cnt==HALF+1, so all decision points and the output latency shift by +1 cycle.
  - The START glitch check uses the majority value.
- Undefined: single sample at cnt==HALF, as above.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - DATA_BITS=8.
  - Function clog2 for the counter width.
- One sub-module, uart_rx_sampler, holds:
  - the 2-FF synchroniser;
  - the optional 3-tap majority shift register;
  - output rx_s, plus sample_bit valid at the decision cycle.
- FSM, counter and handshake stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 8N1 with rx_ready held 0 -> rx_valid rises 2+144+8+1=155 cycles after the start edge; rx_data=0xA5; frame_err=0, overrun=0.
- Back-to-back frames 0x00,0xFF,0x3C with rx_ready=1 (no idle gap) -> three one-cycle rx_valid pulses with correct data, no errors.
- 0x55 with stop bit low, line returned high 3 bits later -> frame_err pulses once, rx_valid stays 0, rx_busy high until the line is high. A following 0x12 is received correctly.
- 0x11 then 0x22 with rx_ready=0 -> overrun pulses once at the second byte, rx_data=0x22, rx_valid=1. Then rx_ready=1 for one cycle -> rx_valid=0.
- Start pulse low for 4 cycles only -> FSM returns to IDLE by cnt==HALF+1, with no rx_valid and no frame_err.
- Assert rst during DATA bit 4 of 0xC3, release, then send 0x7E -> outputs at reset values during reset; only 0x7E is delivered. With UART_RX_MAJORITY_EN, a 1-cycle glitch at HALF of a data bit does not corrupt the byte.
